// File: rtl/pc_gen_if.sv
// Fetch-stage redirect/stall inputs and PC/enable outputs of the program-counter generator.
// The master side is the pipeline control driving redirects; the slave side is pc_gen.
interface pc_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
);
  logic [STALL_W-1:0] i_stall;
  logic               i_flush;
  logic [ADDR_W-1:0]  i_flush_pc;
  logic               i_branch;
  logic [ADDR_W-1:0]  i_branch_pc;
  logic [ADDR_W-1:0]  o_pc;
  logic               o_ce;
  logic               o_pending;
  logic               o_misalign;

  modport master (
    output i_stall, i_flush, i_flush_pc, i_branch, i_branch_pc,
    input  o_pc, o_ce, o_pending, o_misalign
  );

  modport slave (
    input  i_stall, i_flush, i_flush_pc, i_branch, i_branch_pc,
    output o_pc, o_ce, o_pending, o_misalign
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: sequential fetch, flush/branch redirects, a one-entry
// pending slot for branches that arrive while fetch is stalled, and misalignment flagging.
module pc_gen #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                STEP      = 4,
  parameter int                STALL_W   = 6
) (
  input logic   i_clk,
  input logic   i_rst_n,
  pc_gen_if.slave bus
);

  localparam logic [ADDR_W-1:0] STEP_V     = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);

  // STEP=1 yields an all-zero mask, so nothing is ever flagged.
  function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
    return |(addr & ALIGN_MASK);
  endfunction

  logic              ce_p0;
  logic [ADDR_W-1:0] pc_p0;
  logic              pend_p0;
  logic [ADDR_W-1:0] tgt_p0;
  logic              mis_p0;

  logic              next_ce;
  logic [ADDR_W-1:0] next_pc;
  logic              next_pend;
  logic [ADDR_W-1:0] next_tgt;
  logic              next_mis;
  logic              stall;

  assign stall = bus.i_stall[0];

  generate
    if (STALL_W > 1) begin : g_stall_rest
      logic unused_stall;
      assign unused_stall = ^bus.i_stall[STALL_W-1:1];
    end
  endgenerate

  always_comb begin
    next_ce   = 1'b1;
    next_pc   = pc_p0;
    next_pend = pend_p0;
    next_tgt  = tgt_p0;
    next_mis  = 1'b0;
    if (!ce_p0) begin
      next_pc   = RESET_VEC;
      next_pend = 1'b0;
    end else if (bus.i_flush) begin
      next_pc   = bus.i_flush_pc;
      next_pend = 1'b0;
      next_mis  = misaligned(bus.i_flush_pc);
    end else if (!stall) begin
      next_pend = 1'b0;
      if (bus.i_branch) begin
        next_pc  = bus.i_branch_pc;
        next_mis = misaligned(bus.i_branch_pc);
      end else if (pend_p0) begin
        next_pc  = tgt_p0;
        next_mis = misaligned(tgt_p0);
      end else begin
        next_pc  = pc_p0 + STEP_V;
      end
    end else if (bus.i_branch) begin
      // Last captured branch wins while fetch stays stalled.
      next_pend = 1'b1;
      next_tgt  = bus.i_branch_pc;
    end
  end

  // Stage p0: architectural fetch state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ce_p0   <= 1'b0;
      pc_p0   <= RESET_VEC;
      pend_p0 <= 1'b0;
      tgt_p0  <= '0;
      mis_p0  <= 1'b0;
    end else begin
      ce_p0   <= next_ce;
      pc_p0   <= next_pc;
      pend_p0 <= next_pend;
      tgt_p0  <= next_tgt;
      mis_p0  <= next_mis;
    end
  end

  assign bus.o_ce       = ce_p0;
  assign bus.o_pc       = pc_p0;
  assign bus.o_pending  = pend_p0;
  assign bus.o_misalign = mis_p0;

endmodule
